// File: rtl/pipe_ctrl_pkg.sv
// Shared decode tables for the 5-stage pipeline controller: opcode/funct codes, output
// encodings, the per-stage control word and the single-place instruction decoder.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_LUI  = 2'b01;
  localparam logic [1:0] EXT_SIGN = 2'b10;
  localparam logic [1:0] EXT_BEQ  = 2'b11;

  localparam logic [1:0] PC_SEQ   = 2'b00;
  localparam logic [1:0] PC_BEQ   = 2'b01;
  localparam logic [1:0] PC_J     = 2'b10;
  localparam logic [1:0] PC_JR    = 2'b11;

  localparam logic [1:0] RD_RT    = 2'b00;
  localparam logic [1:0] RD_RD    = 2'b01;
  localparam logic [1:0] RD_RA    = 2'b10;

  localparam logic [1:0] M2R_ALU  = 2'b00;
  localparam logic [1:0] M2R_DM   = 2'b01;
  localparam logic [1:0] M2R_PC8  = 2'b10;
  localparam logic [1:0] M2R_HILO = 2'b11;

  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_OR   = 4'b0001;

  // Tuse of a source that is not read; larger than any tnew so it never stalls.
  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic [1:0] ext_op;
    logic [1:0] pc_sel;
    logic       is_beq;
    logic [3:0] alu_op;
    logic [1:0] reg_dst;
    logic       alu_src;
    logic       md_start;
    logic [1:0] md_op;
    logic       md_class;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic [4:0] wa;
    logic [1:0] tnew;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
  } ctrl_word_t;

  localparam ctrl_word_t CW_BUBBLE = '{
    ext_op: EXT_ZERO, pc_sel: PC_SEQ, is_beq: 1'b0, alu_op: ALU_ADD, reg_dst: RD_RT,
    alu_src: 1'b0, md_start: 1'b0, md_op: 2'b00, md_class: 1'b0, mem_read: 1'b0,
    mem_write: 1'b0, mem_to_reg: M2R_ALU, reg_write: 1'b0, wa: 5'd0, tnew: 2'd0,
    tuse_rs: TUSE_NONE, tuse_rt: TUSE_NONE
  };

  function automatic ctrl_word_t decode(input logic [31:0] instr, input logic md_en);
    ctrl_word_t cw;
    logic [5:0] op;
    logic [5:0] fn;
    op = instr[31:26];
    fn = instr[5:0];
    cw = CW_BUBBLE;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADDU, FN_SUBU: begin
            cw.alu_op  = (fn == FN_SUBU) ? ALU_SUB : ALU_ADD;
            cw.reg_dst = RD_RD;
            cw.wa      = instr[15:11];
            cw.tnew    = 2'd1;
            cw.tuse_rs = 2'd1;
            cw.tuse_rt = 2'd1;
          end
          FN_JR: begin
            cw.pc_sel  = PC_JR;
            cw.tuse_rs = 2'd0;
          end
          FN_JALR: begin
            cw.pc_sel     = PC_JR;
            cw.reg_dst    = RD_RD;
            cw.mem_to_reg = M2R_PC8;
            cw.wa         = instr[15:11];
            cw.tuse_rs    = 2'd0;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            if (md_en) begin
              cw.md_start = 1'b1;
              cw.md_op    = fn[1:0];
              cw.md_class = 1'b1;
              cw.tuse_rs  = 2'd1;
              cw.tuse_rt  = 2'd1;
            end
          end
          FN_MFHI, FN_MFLO: begin
            if (md_en) begin
              cw.md_class   = 1'b1;
              cw.reg_dst    = RD_RD;
              cw.mem_to_reg = M2R_HILO;
              cw.wa         = instr[15:11];
              cw.tnew       = 2'd1;
            end
          end
          FN_MTHI, FN_MTLO: begin
            if (md_en) begin
              cw.md_class = 1'b1;
              cw.tuse_rs  = 2'd1;
            end
          end
          default: cw = CW_BUBBLE;
        endcase
      end
      OP_ORI: begin
        cw.alu_src = 1'b1;
        cw.alu_op  = ALU_OR;
        cw.wa      = instr[20:16];
        cw.tnew    = 2'd1;
        cw.tuse_rs = 2'd1;
      end
      OP_LUI: begin
        cw.ext_op  = EXT_LUI;
        cw.alu_src = 1'b1;
        cw.wa      = instr[20:16];
        cw.tnew    = 2'd1;
      end
      OP_LW: begin
        cw.ext_op     = EXT_SIGN;
        cw.alu_src    = 1'b1;
        cw.mem_read   = 1'b1;
        cw.mem_to_reg = M2R_DM;
        cw.wa         = instr[20:16];
        cw.tnew       = 2'd2;
        cw.tuse_rs    = 2'd1;
      end
      OP_SW: begin
        cw.ext_op    = EXT_SIGN;
        cw.alu_src   = 1'b1;
        cw.mem_write = 1'b1;
        cw.tuse_rs   = 2'd1;
        cw.tuse_rt   = 2'd2;
      end
      OP_BEQ: begin
        cw.ext_op  = EXT_BEQ;
        cw.pc_sel  = PC_BEQ;
        cw.is_beq  = 1'b1;
        cw.tuse_rs = 2'd0;
        cw.tuse_rt = 2'd0;
      end
      OP_J: cw.pc_sel = PC_J;
      OP_JAL: begin
        cw.pc_sel     = PC_J;
        cw.reg_dst    = RD_RA;
        cw.mem_to_reg = M2R_PC8;
        cw.wa         = 5'd31;
      end
      default: cw = CW_BUBBLE;
    endcase
    // Writes to $0 are discarded, so wa==0 doubles as "no write" for hazard checks.
    cw.reg_write = (cw.wa != 5'd0);
    return cw;
  endfunction

  function automatic ctrl_word_t advance(input ctrl_word_t cw);
    ctrl_word_t nx;
    nx = cw;
    if (cw.tnew != 2'd0) nx.tnew = cw.tnew - 2'd1;
    return nx;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_unit_md_busy.sv
// Mult/div busy counter: loads the op latency when an MD op leaves E, counts down to idle.
// busy is registered (1-cycle after start); async reset clears it immediately.
module md_busy_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [3:0] cycles_i,
  output logic       busy_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i)             cnt_d = cycles_i;
    else if (cnt_q != 4'd0)  cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 4'd0;
    else        cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != 4'd0);

  // The D-stage MD stall keeps a second MD op out of E while the unit is busy.
  a_no_start_while_busy: assert property (@(posedge clk) disable iff (!rst_n) !(start_i && busy_o));

endmodule

// File: rtl/pipe_ctrl_hazard_unit.sv
// Pipeline control: decodes D once, carries control words through E/M/W, stalls D on
// Tuse/Tnew and mult/div hazards. D outputs are combinational; E/M/W outputs are registered.
module pipe_ctrl_hazard_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter bit          MD_EN       = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_d,
  input  logic        rd_equal,
  output logic [1:0]  ext_op,
  output logic [1:0]  pc_sel,
  output logic [3:0]  alu_op,
  output logic [1:0]  reg_dst,
  output logic        alu_src,
  output logic        md_start,
  output logic [1:0]  md_op,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_to_reg,
  output logic        reg_write,
  output logic        stall,
  output logic        md_busy
);

  ctrl_word_t cw_dec;
  ctrl_word_t e_q, e_d;
  ctrl_word_t m_q, m_d;
  ctrl_word_t w_q, w_d;
  logic [4:0] rs_d, rt_d;
  logic       data_stall, md_stall;
  logic [3:0] md_cycles;
  logic       unused_bits;

  assign cw_dec = decode(instr_d, MD_EN);
  assign rs_d   = instr_d[25:21];
  assign rt_d   = instr_d[20:16];

  function automatic logic src_hit(input logic [4:0] r, input logic [1:0] tuse,
                                   input ctrl_word_t s);
    return (r != 5'd0) && (r == s.wa) && (tuse < s.tnew);
  endfunction

  assign data_stall = src_hit(rs_d, cw_dec.tuse_rs, e_q) || src_hit(rt_d, cw_dec.tuse_rt, e_q) ||
                      src_hit(rs_d, cw_dec.tuse_rs, m_q) || src_hit(rt_d, cw_dec.tuse_rt, m_q);
  assign md_stall   = cw_dec.md_class && (md_busy || e_q.md_start);
  assign stall      = data_stall || md_stall;

  assign e_d = stall ? CW_BUBBLE : cw_dec;
  assign m_d = advance(e_q);
  assign w_d = advance(m_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= CW_BUBBLE;
      m_q <= CW_BUBBLE;
      w_q <= CW_BUBBLE;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  assign md_cycles = e_q.md_op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);

  md_busy_counter u_md_busy (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (e_q.md_start),
    .cycles_i (md_cycles),
    .busy_o   (md_busy)
  );

  assign ext_op     = cw_dec.ext_op;
  assign pc_sel     = (cw_dec.is_beq && !rd_equal) ? PC_SEQ : cw_dec.pc_sel;
  assign alu_op     = e_q.alu_op;
  assign reg_dst    = e_q.reg_dst;
  assign alu_src    = e_q.alu_src;
  assign md_start   = e_q.md_start;
  assign md_op      = e_q.md_op;
  assign mem_read   = m_q.mem_read;
  assign mem_write  = m_q.mem_write;
  assign mem_to_reg = w_q.mem_to_reg;
  assign reg_write  = w_q.reg_write;

  assign unused_bits = ^{w_q, instr_d[10:6]};

endmodule

// File: tb/tb_pipe_ctrl_hazard_unit.sv
// Bench for pipe_ctrl_hazard_unit: instruction-level pipeline model plus directed scenarios.
module tb_pipe_ctrl_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_d = 32'd0;
  logic        rd_equal = 1'b0;
  logic [1:0]  ext_op, pc_sel, reg_dst, md_op, mem_to_reg;
  logic [3:0]  alu_op;
  logic        alu_src, md_start, mem_read, mem_write, reg_write, stall, md_busy;

  always #5 clk = ~clk;

  pipe_ctrl_hazard_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10), .MD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .rd_equal(rd_equal),
    .ext_op(ext_op), .pc_sel(pc_sel), .alu_op(alu_op), .reg_dst(reg_dst),
    .alu_src(alu_src), .md_start(md_start), .md_op(md_op), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .stall(stall), .md_busy(md_busy)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  typedef enum int {
    K_NOP, K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_JR, K_JALR,
    K_MULT, K_MULTU, K_DIV, K_DIVU, K_MFHI, K_MFLO, K_MTHI, K_MTLO
  } kind_e;

  typedef struct packed {
    logic [1:0] ext_op, pc_sel;
    logic [3:0] alu_op;
    logic [1:0] reg_dst;
    logic       alu_src, md_start;
    logic [1:0] md_op;
    logic       mem_read, mem_write;
    logic [1:0] mem_to_reg;
    logic       reg_write, stall, md_busy;
  } exp_t;

  // Model state: instruction words sitting in E, M, W (0 = bubble) and MD cycles left.
  logic [31:0] st[3];
  int          md_left;
  bit          m_last_stall;
  exp_t        ce;

  function automatic kind_e kind_of(input logic [31:0] i);
    if (i[31:26] == 6'h00) begin
      case (i[5:0])
        6'h21: return K_ADDU;  6'h23: return K_SUBU;  6'h08: return K_JR;   6'h09: return K_JALR;
        6'h18: return K_MULT;  6'h19: return K_MULTU; 6'h1a: return K_DIV;  6'h1b: return K_DIVU;
        6'h10: return K_MFHI;  6'h12: return K_MFLO;  6'h11: return K_MTHI; 6'h13: return K_MTLO;
        default: return K_NOP;
      endcase
    end
    case (i[31:26])
      6'h0d: return K_ORI; 6'h0f: return K_LUI; 6'h23: return K_LW; 6'h2b: return K_SW;
      6'h04: return K_BEQ; 6'h02: return K_J;   6'h03: return K_JAL;
      default: return K_NOP;
    endcase
  endfunction

  function automatic logic [4:0] dest_of(input logic [31:0] i);
    case (kind_of(i))
      K_ADDU, K_SUBU, K_JALR, K_MFHI, K_MFLO: return i[15:11];
      K_ORI, K_LUI, K_LW:                     return i[20:16];
      K_JAL:                                  return 5'd31;
      default:                                return 5'd0;
    endcase
  endfunction

  // Cycles until the result exists, for an instruction that entered E 'age' cycles ago.
  function automatic int tnew_at(input logic [31:0] i, input int age);
    int t;
    case (kind_of(i))
      K_LW:                                          t = 2;
      K_ADDU, K_SUBU, K_ORI, K_LUI, K_MFHI, K_MFLO:  t = 1;
      default:                                       t = 0;
    endcase
    return (t - age < 0) ? 0 : t - age;
  endfunction

  function automatic int tuse_rs(input kind_e k);
    case (k)
      K_BEQ, K_JR, K_JALR: return 0;
      K_ADDU, K_SUBU, K_ORI, K_LW, K_SW, K_MULT, K_MULTU, K_DIV, K_DIVU, K_MTHI, K_MTLO: return 1;
      default: return 99;
    endcase
  endfunction

  function automatic int tuse_rt(input kind_e k);
    case (k)
      K_BEQ: return 0;
      K_ADDU, K_SUBU, K_MULT, K_MULTU, K_DIV, K_DIVU: return 1;
      K_SW: return 2;
      default: return 99;
    endcase
  endfunction

  function automatic bit is_md_start(input kind_e k);
    return k inside {K_MULT, K_MULTU, K_DIV, K_DIVU};
  endfunction

  function automatic bit is_md_class(input kind_e k);
    return k inside {K_MULT, K_MULTU, K_DIV, K_DIVU, K_MFHI, K_MFLO, K_MTHI, K_MTLO};
  endfunction

  function automatic exp_t model_eval();
    exp_t x;
    kind_e kd, ke, km, kw;
    logic [4:0] rs, rt;
    bit hz;
    x  = '0;
    kd = kind_of(instr_d);
    ke = kind_of(st[0]);
    km = kind_of(st[1]);
    kw = kind_of(st[2]);
    case (kd)
      K_LUI:      x.ext_op = 2'b01;
      K_LW, K_SW: x.ext_op = 2'b10;
      K_BEQ:      x.ext_op = 2'b11;
      default:    x.ext_op = 2'b00;
    endcase
    case (kd)
      K_BEQ:        x.pc_sel = rd_equal ? 2'b01 : 2'b00;
      K_J, K_JAL:   x.pc_sel = 2'b10;
      K_JR, K_JALR: x.pc_sel = 2'b11;
      default:      x.pc_sel = 2'b00;
    endcase
    x.alu_op  = (ke == K_SUBU) ? 4'b0110 : (ke == K_ORI) ? 4'b0001 : 4'b0010;
    x.reg_dst = (ke inside {K_ADDU, K_SUBU, K_JALR, K_MFHI, K_MFLO}) ? 2'b01 :
                (ke == K_JAL) ? 2'b10 : 2'b00;
    x.alu_src  = ke inside {K_ORI, K_LUI, K_LW, K_SW};
    x.md_start = is_md_start(ke);
    case (ke)
      K_MULTU: x.md_op = 2'b01;
      K_DIV:   x.md_op = 2'b10;
      K_DIVU:  x.md_op = 2'b11;
      default: x.md_op = 2'b00;
    endcase
    x.mem_read  = (km == K_LW);
    x.mem_write = (km == K_SW);
    x.mem_to_reg = (kw == K_LW) ? 2'b01 : (kw inside {K_JAL, K_JALR}) ? 2'b10 :
                   (kw inside {K_MFHI, K_MFLO}) ? 2'b11 : 2'b00;
    x.reg_write = (dest_of(st[2]) != 5'd0);
    rs = instr_d[25:21];
    rt = instr_d[20:16];
    hz = 1'b0;
    for (int a = 0; a < 2; a++) begin
      if (rs != 5'd0 && rs == dest_of(st[a]) && tuse_rs(kd) < tnew_at(st[a], a)) hz = 1'b1;
      if (rt != 5'd0 && rt == dest_of(st[a]) && tuse_rt(kd) < tnew_at(st[a], a)) hz = 1'b1;
    end
    x.md_busy = (md_left > 0);
    x.stall   = hz || (is_md_class(kd) && (md_left > 0 || is_md_start(ke)));
    return x;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) st[i] = 32'd0;
    md_left = 0;
    m_last_stall = 1'b0;
  endtask

  task automatic step();
    exp_t e;
    kind_e ke;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      e  = model_eval();
      ke = kind_of(st[0]);
      m_last_stall = e.stall;
      if (is_md_start(ke))  md_left = (ke == K_DIV || ke == K_DIVU) ? 10 : 5;
      else if (md_left > 0) md_left--;
      st[2] = st[1];
      st[1] = st[0];
      st[0] = e.stall ? 32'd0 : instr_d;
    end
    #1;
  endtask

  // Present an instruction in D and hold it until it has moved into E.
  task automatic issue(input logic [31:0] ins, output int stalls, output int busy_cnt);
    logic s;
    instr_d  = ins;
    stalls   = 0;
    busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      s = stall;
      if (md_busy) busy_cnt++;
      step();
      if (!s) break;
      stalls++;
    end
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs, rt,
                                         input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [4:0] rreg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 5'd31 : 5'(r);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, c;
    logic [15:0] imm;
    int k;
    a = rreg(); b = rreg(); c = rreg();
    imm = 16'($urandom);
    k = $urandom_range(0, 19);
    case (k)
      0:  return r_type(a, b, c, 6'h21);
      1:  return r_type(a, b, c, 6'h23);
      2:  return r_type(a, b, c, 6'h08);
      3:  return r_type(a, b, c, 6'h09);
      4:  return r_type(a, b, c, 6'h18);
      5:  return r_type(a, b, c, 6'h19);
      6:  return r_type(a, b, c, 6'h1a);
      7:  return r_type(a, b, c, 6'h1b);
      8:  return r_type(a, b, c, 6'h10);
      9:  return r_type(a, b, c, 6'h12);
      10: return r_type(a, b, c, 6'h11);
      11: return r_type(a, b, c, 6'h13);
      12: return i_type(6'h0d, a, b, imm);
      13: return i_type(6'h0f, a, b, imm);
      14: return i_type(6'h23, a, b, imm);
      15: return i_type(6'h2b, a, b, imm);
      16: return i_type(6'h04, a, b, imm);
      17: return {6'h02, 26'($urandom)};
      18: return {6'h03, 26'($urandom)};
      default: return 32'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      ce = model_eval();
      cmp("ext_op",     32'(ext_op),     32'(ce.ext_op));
      cmp("pc_sel",     32'(pc_sel),     32'(ce.pc_sel));
      cmp("alu_op",     32'(alu_op),     32'(ce.alu_op));
      cmp("reg_dst",    32'(reg_dst),    32'(ce.reg_dst));
      cmp("alu_src",    32'(alu_src),    32'(ce.alu_src));
      cmp("md_start",   32'(md_start),   32'(ce.md_start));
      cmp("md_op",      32'(md_op),      32'(ce.md_op));
      cmp("mem_read",   32'(mem_read),   32'(ce.mem_read));
      cmp("mem_write",  32'(mem_write),  32'(ce.mem_write));
      cmp("mem_to_reg", 32'(mem_to_reg), 32'(ce.mem_to_reg));
      cmp("reg_write",  32'(reg_write),  32'(ce.reg_write));
      cmp("stall",      32'(stall),      32'(ce.stall));
      cmp("md_busy",    32'(md_busy),    32'(ce.md_busy));
    end
  end

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] NOP = 32'd0;

  initial begin
    int ns, nb;
    model_reset();
    step();
    cmp("rst_alu_op", 32'(alu_op), 32'h2);
    cmp("rst_md_busy", 32'(md_busy), 32'h0);
    cmp("rst_stall", 32'(stall), 32'h0);
    cmp("rst_reg_write", 32'(reg_write), 32'h0);
    step();
    rst_n = 1'b1;
    chk_en = 1'b1;

    // lw then dependent addu: one bubble
    issue(i_type(6'h23, 5'd0, 5'd1, 16'd0), ns, nb);
    issue(r_type(5'd1, 5'd1, 5'd2, 6'h21), ns, nb);
    cmp("lw_use_stalls", 32'(ns), 32'd1);
    cmp("lw_use_alu_op", 32'(alu_op), 32'h2);
    cmp("lw_use_reg_dst", 32'(reg_dst), 32'h1);

    // ALU / load result feeding beq
    issue(r_type(5'd4, 5'd5, 5'd3, 6'h21), ns, nb);
    issue(i_type(6'h04, 5'd3, 5'd0, 16'd1), ns, nb);
    cmp("alu_beq_stalls", 32'(ns), 32'd1);
    issue(i_type(6'h23, 5'd0, 5'd3, 16'd0), ns, nb);
    issue(i_type(6'h04, 5'd3, 5'd0, 16'd1), ns, nb);
    cmp("lw_beq_stalls", 32'(ns), 32'd2);

    // mult then mflo
    issue(r_type(5'd1, 5'd2, 5'd0, 6'h18), ns, nb);
    cmp("mult_md_start", 32'(md_start), 32'h1);
    cmp("mult_md_op", 32'(md_op), 32'h0);
    issue(r_type(5'd0, 5'd0, 5'd4, 6'h12), ns, nb);
    cmp("mflo_stalls", 32'(ns), 32'd6);
    cmp("mflo_busy_cycles", 32'(nb), 32'd5);
    cmp("mflo_in_e_reg_dst", 32'(reg_dst), 32'h1);

    // jal through the pipe
    instr_d = {6'h03, 26'h0000100};
    #1;
    cmp("jal_pc_sel", 32'(pc_sel), 32'h2);
    issue({6'h03, 26'h0000100}, ns, nb);
    cmp("jal_reg_dst", 32'(reg_dst), 32'h2);
    instr_d = NOP;
    step();
    step();
    cmp("jal_mem_to_reg", 32'(mem_to_reg), 32'h2);
    cmp("jal_reg_write", 32'(reg_write), 32'h1);

    // write to $0 never creates a hazard and never writes
    issue(r_type(5'd1, 5'd2, 5'd0, 6'h21), ns, nb);
    cmp("zero_dst_stalls", 32'(ns), 32'd0);
    instr_d = i_type(6'h04, 5'd0, 5'd0, 16'd1);
    rd_equal = 1'b1;
    #1;
    cmp("beq_taken_pc_sel", 32'(pc_sel), 32'h1);
    rd_equal = 1'b0;
    #1;
    cmp("beq_not_taken_pc_sel", 32'(pc_sel), 32'h0);
    issue(i_type(6'h04, 5'd0, 5'd0, 16'd1), ns, nb);
    cmp("beq_zero_stalls", 32'(ns), 32'd0);
    instr_d = NOP;
    step();
    cmp("zero_dst_reg_write", 32'(reg_write), 32'h0);

    // reset in the middle of a divide
    issue(r_type(5'd1, 5'd2, 5'd0, 6'h1a), ns, nb);
    issue({6'h03, 26'h0000200}, ns, nb);
    issue(i_type(6'h23, 5'd0, 5'd8, 16'd4), ns, nb);
    issue(r_type(5'd1, 5'd1, 5'd9, 6'h21), ns, nb);
    issue(i_type(6'h0d, 5'd0, 5'd10, 16'd1), ns, nb);
    cmp("div_busy_before_rst", 32'(md_busy), 32'h1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    cmp("arst_md_busy", 32'(md_busy), 32'h0);
    cmp("arst_alu_src", 32'(alu_src), 32'h0);
    cmp("arst_reg_dst", 32'(reg_dst), 32'h0);
    cmp("arst_mem_to_reg", 32'(mem_to_reg), 32'h0);
    cmp("arst_reg_write", 32'(reg_write), 32'h0);
    instr_d = r_type(5'd3, 5'd4, 5'd2, 6'h21);
    step();
    step();
    rst_n = 1'b1;
    issue(r_type(5'd3, 5'd4, 5'd2, 6'h21), ns, nb);
    cmp("post_rst_stalls", 32'(ns), 32'd0);
    cmp("post_rst_reg_dst", 32'(reg_dst), 32'h1);
    cmp("post_rst_md_busy", 32'(md_busy), 32'h0);

    // random instruction stream; D is held while the model says stall
    for (int n = 0; n < 3000; n++) begin
      if (!m_last_stall) instr_d = rand_instr();
      rd_equal = 1'($urandom_range(0, 1));
      step();
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
